// File: rtl/seg7_pkg.sv
// rtl/seg7_pkg.sv - shared glyph encodings, FSM states and lookup result type for the 7-segment receiver
package seg7_pkg;

  // Active-low segment patterns, bit6=g ... bit0=a
  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_A     = 7'b0001000;
  localparam logic [6:0] SEG_B     = 7'b0000011;
  localparam logic [6:0] SEG_C     = 7'b0100111;
  localparam logic [6:0] SEG_D     = 7'b0100001;
  localparam logic [6:0] SEG_E     = 7'b0000110;
  localparam logic [6:0] SEG_F     = 7'b0001110;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_7_ALT = 7'b1011000;
  localparam logic [6:0] SEG_9_ALT = 7'b0011000;

  localparam logic [0:0] ST_WAIT = 1'b0;
  localparam logic [0:0] ST_HOLD = 1'b1;

  // legal marks a digit glyph; blank is reported separately and is not legal
  typedef struct packed {
    logic       legal;
    logic       blank;
    logic [3:0] digit;
  } glyph_t;

endpackage

// File: rtl/seg7_pattern_rx_if.sv
// rtl/seg7_pattern_rx_if.sv - decoded digit valid/ready handshake between receiver and consumer
interface seg7_pattern_rx_if;
  logic [3:0] hex_out;
  logic       hex_valid;
  logic       out_ready;

  modport master (output hex_out, output hex_valid, input out_ready);
  modport slave  (input hex_out, input hex_valid, output out_ready);
endinterface

// File: rtl/seg7_glyph_lookup.sv
// rtl/seg7_glyph_lookup.sv - combinational segment pattern to digit decode; SEG7_ALT_GLYPH_EN adds alternate 7/9 glyphs
module seg7_glyph_lookup
  import seg7_pkg::*;
(
  input  logic [6:0] pattern,
  output glyph_t     glyph
);

`ifdef SEG7_ALT_GLYPH_EN
  localparam bit ALT_EN = 1'b1;
`else
  localparam bit ALT_EN = 1'b0;
`endif

  always_comb begin
    glyph.legal = 1'b1;
    glyph.blank = 1'b0;
    glyph.digit = 4'h0;
    case (pattern)
      SEG_0: glyph.digit = 4'h0;
      SEG_1: glyph.digit = 4'h1;
      SEG_2: glyph.digit = 4'h2;
      SEG_3: glyph.digit = 4'h3;
      SEG_4: glyph.digit = 4'h4;
      SEG_5: glyph.digit = 4'h5;
      SEG_6: glyph.digit = 4'h6;
      SEG_7: glyph.digit = 4'h7;
      SEG_8: glyph.digit = 4'h8;
      SEG_9: glyph.digit = 4'h9;
      SEG_A: glyph.digit = 4'hA;
      SEG_B: glyph.digit = 4'hB;
      SEG_C: glyph.digit = 4'hC;
      SEG_D: glyph.digit = 4'hD;
      SEG_E: glyph.digit = 4'hE;
      SEG_F: glyph.digit = 4'hF;
      SEG_7_ALT: begin
        glyph.legal = ALT_EN;
        glyph.digit = 4'h7;
      end
      SEG_9_ALT: begin
        glyph.legal = ALT_EN;
        glyph.digit = 4'h9;
      end
      SEG_BLANK: begin
        glyph.legal = 1'b0;
        glyph.blank = 1'b1;
      end
      default: glyph.legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/seg7_pattern_rx.sv
// rtl/seg7_pattern_rx.sv - 7-segment bus receiver: sync, stability filter, digit emit, illegal-glyph counter (SEG7_ALT_GLYPH_EN)
module seg7_pattern_rx
  import seg7_pkg::*;
#(
  parameter int STABLE_CYCLES = 4,
  parameter int ERR_W         = 8
) (
  input  logic               CLOCK_50,
  input  logic               resetn,
  input  logic [6:0]         seg_in,
  seg7_pattern_rx_if.master  hex_if,
  output logic               bad_pattern,
  output logic [ERR_W-1:0]   err_count
);

  localparam logic [7:0] STABLE_MAX = 8'(STABLE_CYCLES);

  logic [6:0] sync1, s, last;
  logic [7:0] cnt;
  logic [0:0] state;
  logic [3:0] hex_q;
  logic       valid_q;
  glyph_t     glyph;

  seg7_glyph_lookup u_lookup (
    .pattern (s),
    .glyph   (glyph)
  );

  assign hex_if.hex_out   = hex_q;
  assign hex_if.hex_valid = valid_q;

  // cnt compares the incoming sample against s, so it clears on the same edge s changes
  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      sync1       <= SEG_BLANK;
      s           <= SEG_BLANK;
      last        <= SEG_BLANK;
      cnt         <= 8'd0;
      state       <= ST_WAIT;
      hex_q       <= 4'h0;
      valid_q     <= 1'b0;
      bad_pattern <= 1'b0;
      err_count   <= '0;
    end else begin
      sync1       <= seg_in;
      s           <= sync1;
      bad_pattern <= 1'b0;

      if (sync1 != s) begin
        cnt <= 8'd0;
      end else if (cnt != STABLE_MAX) begin
        cnt <= cnt + 8'd1;
      end

      if (state == ST_WAIT) begin
        if (cnt == STABLE_MAX && s != last) begin
          last <= s;
          if (glyph.legal) begin
            hex_q   <= glyph.digit;
            valid_q <= 1'b1;
            state   <= ST_HOLD;
          end else if (!glyph.blank) begin
            bad_pattern <= 1'b1;
            if (err_count != '1) begin
              err_count <= err_count + 1'b1;
            end
          end
        end
      end else begin
        if (valid_q && hex_if.out_ready) begin
          valid_q <= 1'b0;
          state   <= ST_WAIT;
        end
      end
    end
  end

endmodule

// File: tb/tb_seg7_pattern_rx.sv
// tb/tb_seg7_pattern_rx.sv - scoreboard bench for seg7_pattern_rx; honours SEG7_ALT_GLYPH_EN
module tb_seg7_pattern_rx;

  logic       CLOCK_50 = 1'b0;
  logic       resetn   = 1'b0;
  logic [6:0] seg_in   = 7'b1111111;
  logic       bad_pattern;
  logic [7:0] err_count;

  seg7_pattern_rx_if hif ();

  seg7_pattern_rx #(.STABLE_CYCLES(4), .ERR_W(8)) dut (
    .CLOCK_50    (CLOCK_50),
    .resetn      (resetn),
    .seg_in      (seg_in),
    .hex_if      (hif),
    .bad_pattern (bad_pattern),
    .err_count   (err_count)
  );

  always #10 CLOCK_50 = ~CLOCK_50;

  logic [6:0] glyphs [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b0100111, 7'b0100001, 7'b0000110, 7'b0001110
  };
  localparam logic [6:0] ILLEGAL = 7'b1010101;
  localparam logic [6:0] BLANK   = 7'b1111111;

  int         tests = 0;
  int         fails = 0;
  int         accepts = 0;
  int         bad_pulses = 0;
  logic       bad_prev = 1'b0;
  logic [3:0] exp_q [$];
  int         a0, b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge CLOCK_50);
    #3;
  endtask

  always @(negedge CLOCK_50) begin
    if (resetn) begin
      if (hif.hex_valid && hif.out_ready) begin
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_emit: got %0h expected none", hif.hex_out);
        end else begin
          check("emit_digit", {28'd0, hif.hex_out}, {28'd0, exp_q.pop_front()});
        end
        accepts++;
      end
      if (bad_pattern) begin
        check("bad_width", {31'd0, bad_prev}, 32'd0);
        bad_pulses++;
      end
    end
    bad_prev = bad_pattern;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    hif.out_ready = 1'b1;
    step(3);
    check("rst_valid", {31'd0, hif.hex_valid}, 32'd0);
    check("rst_hex", {28'd0, hif.hex_out}, 32'd0);
    check("rst_bad", {31'd0, bad_pattern}, 32'd0);
    check("rst_err", {24'd0, err_count}, 32'd0);
    resetn = 1'b1;
    step(2);

    // latency: valid on the 7th edge after the change, one cycle wide
    a0 = accepts;
    seg_in = glyphs[1];
    exp_q.push_back(4'h1);
    repeat (6) @(posedge CLOCK_50);
    #1 check("lat_early", {31'd0, hif.hex_valid}, 32'd0);
    @(posedge CLOCK_50);
    #1 check("lat_valid", {31'd0, hif.hex_valid}, 32'd1);
    check("lat_hex", {28'd0, hif.hex_out}, 32'd1);
    @(posedge CLOCK_50);
    #1 check("lat_width", {31'd0, hif.hex_valid}, 32'd0);
    step(20);
    check("no_reemit", accepts - a0, 32'd1);

    a0 = accepts;
    for (int d = 0; d < 16; d++) begin
      seg_in = glyphs[d];
      exp_q.push_back(4'(d));
      step(10);
    end
    check("sweep_count", accepts - a0, 32'd16);
    check("sweep_err", {24'd0, err_count}, 32'd0);
    check("sweep_q", exp_q.size(), 32'd0);

    hif.out_ready = 1'b0;
    seg_in = glyphs[3];
    exp_q.push_back(4'h3);
    exp_q.push_back(4'h5);
    step(12);
    check("bp_valid1", {31'd0, hif.hex_valid}, 32'd1);
    check("bp_hex1", {28'd0, hif.hex_out}, 32'd3);
    seg_in = glyphs[5];
    step(12);
    check("bp_valid2", {31'd0, hif.hex_valid}, 32'd1);
    check("bp_hex2", {28'd0, hif.hex_out}, 32'd3);
    a0 = accepts;
    hif.out_ready = 1'b1;
    step(12);
    check("bp_count", accepts - a0, 32'd2);
    check("bp_q", exp_q.size(), 32'd0);

    b0 = bad_pulses;
    seg_in = ILLEGAL;
    step(10);
    check("ill_err1", {24'd0, err_count}, 32'd1);
    check("ill_pulse1", bad_pulses - b0, 32'd1);
    for (int i = 0; i < 300; i++) begin
      seg_in = BLANK;
      step(8);
      seg_in = ILLEGAL;
      step(8);
    end
    check("ill_sat", {24'd0, err_count}, 32'd255);
    check("ill_pulses", bad_pulses - b0, 32'd301);
    seg_in = BLANK;
    step(8);

    // a 2-sample glitch must never reach the stability threshold
    a0 = accepts;
    b0 = bad_pulses;
    seg_in = glyphs[2];
    exp_q.push_back(4'h2);
    step(10);
    seg_in = 7'b0000000;
    step(2);
    seg_in = glyphs[2];
    step(15);
    check("glitch_emit", accepts - a0, 32'd1);
    check("glitch_bad", bad_pulses - b0, 32'd0);
    check("glitch_q", exp_q.size(), 32'd0);

    hif.out_ready = 1'b0;
    seg_in = glyphs[8];
    step(10);
    check("hold_valid", {31'd0, hif.hex_valid}, 32'd1);
    check("hold_hex", {28'd0, hif.hex_out}, 32'd8);
    resetn = 1'b0;
    #1;
    check("arst_valid", {31'd0, hif.hex_valid}, 32'd0);
    check("arst_err", {24'd0, err_count}, 32'd0);
    check("arst_hex", {28'd0, hif.hex_out}, 32'd0);
    seg_in = BLANK;
    step(2);
    resetn = 1'b1;
    hif.out_ready = 1'b1;
    step(10);

    a0 = accepts;
    b0 = bad_pulses;
    seg_in = 7'b1011000;
`ifdef SEG7_ALT_GLYPH_EN
    exp_q.push_back(4'h7);
`endif
    step(10);
`ifdef SEG7_ALT_GLYPH_EN
    check("alt_emit", accepts - a0, 32'd1);
    check("alt_err", {24'd0, err_count}, 32'd0);
`else
    check("alt_emit", accepts - a0, 32'd0);
    check("alt_bad", bad_pulses - b0, 32'd1);
    check("alt_err", {24'd0, err_count}, 32'd1);
`endif
    check("alt_q", exp_q.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/seg7_pattern_rx.md
Name: seg7_pattern_rx

Overview:
- Receive end of the 7-segment display interface: samples an active-low segment bus (HEX-style drive) and recovers the 4-bit hex digit it shows.
- Filters glitches with a stability window.
- Emits each newly stable digit once over a valid/ready handshake.
- Flags and counts patterns that are not legal glyphs.
- Sits between a monitored HEX bus (or loopback of the display driver output) and checker/logging logic.

Parameters:
- STABLE_CYCLES, 4, consecutive identical synchronized samples required before a pattern is accepted (legal range 1..255).
- ERR_W, 8, width of the saturating error counter.

Ports:
- CLOCK_50  input  1  system clock, rising edge.
- resetn  input  1  asynchronous active-low reset.
- seg_in  input  7  segment bus, active-low; bit6=g … bit0=a; asynchronous to CLOCK_50.
- out_ready  input  1  consumer accepts hex_out when high with hex_valid.
- hex_out  output  4  decoded digit 0x0..0xF.
- hex_valid  output  1  hex_out is valid.
- bad_pattern  output  1  one-cycle pulse per stable illegal pattern.
- err_count  output  ERR_W  saturating count of illegal patterns.

Behaviour:
- Interface: one clock (CLOCK_50). Reset (resetn) is asynchronous, active-low.
- Reset values:
  - hex_out=0, hex_valid=0, bad_pattern=0, err_count=0.
  - Synchronizer flops and last-pattern register load 7'b1111111 (blank).
  - Stability counter=0; FSM=WAIT.
- Reset mid-operation: immediate clear of all state, including a pending unaccepted digit.
- Input path: seg_in passes through a 2-flop synchronizer, giving s.
- Stability counter:
  - Increments when s equals its previous value; clears to 0 when s changes.
  - Saturates at STABLE_CYCLES.
- Legal glyphs (g..a):
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000
  - 4=0011001, 5=0010010, 6=0000010, 7=1111000
  - 8=0000000, 9=0010000, A=0001000, b=0000011
  - c=0100111, d=0100001, E=0000110, F=0001110
  - Blank=1111111.
- FSM states:
  - WAIT: when the counter reaches STABLE_CYCLES and s differs from the last-pattern register:
    - Legal glyph: latch the digit into hex_out and s into last-pattern; next edge hex_valid=1; go to HOLD.
    - Blank: update last-pattern; no output; stay in WAIT.
    - Illegal: bad_pattern=1 for exactly one cycle; err_count+1, saturating at all-ones; update last-pattern; stay in WAIT.
  - HOLD: hex_out and hex_valid are held constant until hex_valid&&out_ready. On that edge hex_valid=0, go to WAIT.
- Repeated patterns: the same stable pattern is never re-emitted or re-counted. A different pattern must become stable first.
- Latency: with a clean change and out_ready=1, hex_valid rises on edge 2+STABLE_CYCLES+1 after the change (7 at default).
- seg_in changes during HOLD:
  - The pending digit is never dropped or altered.
  - The synchronizer and counter keep running.
  - The new pattern is evaluated in WAIT once it is stable.
- Glitches shorter than STABLE_CYCLES samples produce no output and no error.
- out_ready high while hex_valid=0 has no effect.

Optional Feature:
- Macro: SEG7_ALT_GLYPH_EN.
- Defined: two additional encodings are also legal:
  - 7 with segment f lit: 1011000 → 0x7.
  - 9 without segment d: 0011000 → 0x9.
- Undefined: both alternate patterns are illegal (bad_pattern pulse, err_count increment).

Decomposition:
- Package seg7_pkg holds:
  - Glyph constants SEG_0..SEG_F and SEG_BLANK.
  - Alternate glyph constants SEG_7_ALT and SEG_9_ALT.
  - FSM state enum {WAIT, HOLD}.
- Sub-module seg7_glyph_lookup: combinational 7-bit pattern → {legal, blank, digit[3:0]}. It contains the SEG7_ALT_GLYPH_EN conditional and is reusable by other display checkers.

Test Plan:
- Reset, then seg_in=1111001 held, out_ready=1 → hex_valid high on the 7th edge with hex_out=0x1, one cycle wide; no re-emission while seg_in is unchanged.
- Sweep all 16 glyphs, each held 10 cycles, out_ready=1 → hex_out sequence 0x0..0xF, exactly 16 valid pulses, err_count=0.
- out_ready=0; send 0x3 (0110000) then change to 0x5 (0010010) → hex_out stays 0x3 with valid high. Raise out_ready → 0x3 accepted, then 0x5 emitted.
- seg_in=1010101 held 10 cycles → single bad_pattern pulse, err_count=1; 300 alternating illegal/blank patterns → err_count saturates at 255.
- 2-cycle glitch to 0000000 during stable 0x2 → no valid, no error. Assert resetn=0 while in HOLD → hex_valid and err_count clear immediately.
- seg_in=1011000 held → with SEG7_ALT_GLYPH_EN defined, hex_out=0x7 valid; without it, bad_pattern pulse and err_count=1.
